// File: rtl/video_pkg.sv
// Shared raster constants and helpers for the native-rate video timing path.
// Holds the ZX Spectrum 48K/128K line/frame geometry and the colour depth helper.
package video_pkg;

    localparam int CNT_W = 9;

    localparam int ZX48_H_TOTAL  = 448;
    localparam int ZX48_H_ACTIVE = 256;
    localparam int ZX48_H_SS     = 320;
    localparam int ZX48_H_SW     = 32;
    localparam int ZX48_V_TOTAL  = 312;
    localparam int ZX48_V_ACTIVE = 192;
    localparam int ZX48_V_SS     = 248;
    localparam int ZX48_V_SW     = 4;

    // The 128K machine stretches each line and drops one line per frame.
    localparam int ZX128_H_TOTAL = 456;
    localparam int ZX128_V_TOTAL = 311;

    function automatic int dwidth(input int half_depth);
        return (half_depth != 0) ? 2 : 5;
    endfunction

endpackage

// File: rtl/video_sync_counter.sv
// Pixel-enable divider plus horizontal/vertical raster counters.
// Counters advance only on the registered pixel enable.
module video_sync_counter
    import video_pkg::*;
#(
    parameter int CE_DIV  = 4,
    parameter int H_TOTAL = ZX48_H_TOTAL,
    parameter int V_TOTAL = ZX48_V_TOTAL
) (
    input  logic             clk_sys,
    input  logic             reset,
    output logic             ce_pix,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y
);

    localparam int DIV_W = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CE_DIV - 1);
    localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(V_TOTAL - 1);

    logic [DIV_W-1:0] div_reg, div_next;
    logic             ce_reg, ce_next;
    logic [CNT_W-1:0] x_reg, x_next;
    logic [CNT_W-1:0] y_reg, y_next;

    always_comb begin
        div_next = (div_reg == DIV_LAST) ? '0 : div_reg + 1'b1;
        ce_next  = (div_reg == DIV_LAST);
        x_next   = x_reg;
        y_next   = y_reg;
        if (ce_reg) begin
            if (x_reg == X_LAST) begin
                x_next = '0;
                y_next = (y_reg == Y_LAST) ? '0 : y_reg + 1'b1;
            end else begin
                x_next = x_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            div_reg <= '0;
            ce_reg  <= 1'b0;
            x_reg   <= '0;
            y_reg   <= '0;
        end else begin
            div_reg <= div_next;
            ce_reg  <= ce_next;
            x_reg   <= x_next;
            y_reg   <= y_next;
        end
    end

    assign ce_pix = ce_reg;
    assign pix_x  = x_reg;
    assign pix_y  = y_reg;

endmodule

// File: rtl/video_timing_gen.sv
// Native-rate raster generator: exports the coordinate to the pixel source and
// returns sync, blanking and blanked RGB for that coordinate one pixel enable later.
module video_timing_gen
    import video_pkg::*;
#(
    parameter int CE_DIV     = 4,
    parameter int H_TOTAL    = ZX48_H_TOTAL,
    parameter int H_ACTIVE   = ZX48_H_ACTIVE,
    parameter int H_SS       = ZX48_H_SS,
    parameter int H_SW       = ZX48_H_SW,
    parameter int V_TOTAL    = ZX48_V_TOTAL,
    parameter int V_ACTIVE   = ZX48_V_ACTIVE,
    parameter int V_SS       = ZX48_V_SS,
    parameter int V_SW       = ZX48_V_SW,
    parameter int HALF_DEPTH = 0,
    localparam int DWIDTH    = dwidth(HALF_DEPTH)
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    input  logic [3*(DWIDTH+1)-1:0] rgb_in,
    output logic                    ce_pix,
    output logic [CNT_W-1:0]        pix_x,
    output logic [CNT_W-1:0]        pix_y,
    output logic                    hs_out,
    output logic                    vs_out,
    output logic                    hblank,
    output logic                    vblank,
    output logic                    line_start,
    output logic [DWIDTH:0]         r_out,
    output logic [DWIDTH:0]         g_out,
    output logic [DWIDTH:0]         b_out
);

    localparam int RGB_W = 3 * (DWIDTH + 1);
    // One extra bit so sync end positions equal to 512 still compare correctly.
    localparam int EXT_W = CNT_W + 1;
    localparam logic [EXT_W-1:0] H_ACT_C = EXT_W'(H_ACTIVE);
    localparam logic [EXT_W-1:0] H_SS_C  = EXT_W'(H_SS);
    localparam logic [EXT_W-1:0] H_SE_C  = EXT_W'(H_SS + H_SW);
    localparam logic [EXT_W-1:0] V_ACT_C = EXT_W'(V_ACTIVE);
    localparam logic [EXT_W-1:0] V_SS_C  = EXT_W'(V_SS);
    localparam logic [EXT_W-1:0] V_SE_C  = EXT_W'(V_SS + V_SW);

    generate
        if (CE_DIV < 1 || CE_DIV > 16) begin : g_bad_div
            $error("video_timing_gen: CE_DIV must be 1..16");
        end
        if (H_TOTAL > 512 || V_TOTAL > 512) begin : g_bad_total
            $error("video_timing_gen: H_TOTAL/V_TOTAL must not exceed 512");
        end
        if (H_ACTIVE > H_SS || H_SS + H_SW > H_TOTAL || H_SW < 1) begin : g_bad_h
            $error("video_timing_gen: illegal horizontal geometry");
        end
        if (V_ACTIVE > V_SS || V_SS + V_SW > V_TOTAL || V_SW < 1) begin : g_bad_v
            $error("video_timing_gen: illegal vertical geometry");
        end
    endgenerate

    logic             ce_int;
    logic [CNT_W-1:0] x_int, y_int;

    video_sync_counter #(
        .CE_DIV  (CE_DIV),
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL)
    ) u_counter (
        .clk_sys (clk_sys),
        .reset   (reset),
        .ce_pix  (ce_int),
        .pix_x   (x_int),
        .pix_y   (y_int)
    );

    logic [EXT_W-1:0] x_ext, y_ext;
    logic             hblank_reg, hblank_next;
    logic             vblank_reg, vblank_next;
    logic             hs_reg, hs_next;
    logic             vs_reg, vs_next;
    logic             ls_reg, ls_next;
    logic [RGB_W-1:0] rgb_reg, rgb_next;

    assign x_ext = {1'b0, x_int};
    assign y_ext = {1'b0, y_int};

    // vs_next depends only on the line count, so it can only change at a line wrap.
    always_comb begin
        hblank_next = (x_ext >= H_ACT_C);
        vblank_next = (y_ext >= V_ACT_C);
        hs_next     = (x_ext >= H_SS_C) && (x_ext < H_SE_C);
        vs_next     = (y_ext >= V_SS_C) && (y_ext < V_SE_C);
        ls_next     = (x_int == '0);
        rgb_next    = (hblank_next || vblank_next) ? '0 : rgb_in;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            hblank_reg <= 1'b1;
            vblank_reg <= 1'b1;
            hs_reg     <= 1'b0;
            vs_reg     <= 1'b0;
            ls_reg     <= 1'b0;
            rgb_reg    <= '0;
        end else if (ce_int) begin
            hblank_reg <= hblank_next;
            vblank_reg <= vblank_next;
            hs_reg     <= hs_next;
            vs_reg     <= vs_next;
            ls_reg     <= ls_next;
            rgb_reg    <= rgb_next;
        end
    end

    assign ce_pix     = ce_int;
    assign pix_x      = x_int;
    assign pix_y      = y_int;
    assign hs_out     = hs_reg;
    assign vs_out     = vs_reg;
    assign hblank     = hblank_reg;
    assign vblank     = vblank_reg;
    assign line_start = ls_reg;
    assign r_out      = rgb_reg[DWIDTH:0];
    assign g_out      = rgb_reg[2*DWIDTH+1:DWIDTH+1];
    assign b_out      = rgb_reg[RGB_W-1:2*DWIDTH+2];

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen: default 48K geometry, a compact
// CE_DIV=1 geometry for whole-frame monitoring, and a tiny 3-bit-colour geometry.
module tb_video_timing_gen;

    logic clk;
    logic reset;
    logic mon_en;
    logic rst_seen;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) rst_seen <= reset;

    // ---------------- default geometry, CE_DIV=4 ----------------
    logic        d_ce, d_hs, d_vs, d_hb, d_vb, d_ls;
    logic [8:0]  d_x, d_y;
    logic [5:0]  d_r, d_g, d_b;
    logic [17:0] d_rgb;
    assign d_rgb = {d_y[5:0], d_x[5:0], 6'h2A};

    video_timing_gen u_def (
        .clk_sys(clk), .reset(reset), .rgb_in(d_rgb), .ce_pix(d_ce),
        .pix_x(d_x), .pix_y(d_y), .hs_out(d_hs), .vs_out(d_vs),
        .hblank(d_hb), .vblank(d_vb), .line_start(d_ls),
        .r_out(d_r), .g_out(d_g), .b_out(d_b)
    );

    // ---------------- compact geometry, CE_DIV=1 ----------------
    logic        m_ce, m_hs, m_vs, m_hb, m_vb, m_ls;
    logic [8:0]  m_x, m_y;
    logic [5:0]  m_r, m_g, m_b;
    logic [17:0] m_rgb;
    assign m_rgb = {m_y[5:0], m_x[5:0], 6'h2A};

    video_timing_gen #(
        .CE_DIV(1), .H_TOTAL(64), .H_ACTIVE(32), .H_SS(40), .H_SW(8),
        .V_TOTAL(40), .V_ACTIVE(24), .V_SS(30), .V_SW(3), .HALF_DEPTH(0)
    ) u_mid (
        .clk_sys(clk), .reset(reset), .rgb_in(m_rgb), .ce_pix(m_ce),
        .pix_x(m_x), .pix_y(m_y), .hs_out(m_hs), .vs_out(m_vs),
        .hblank(m_hb), .vblank(m_vb), .line_start(m_ls),
        .r_out(m_r), .g_out(m_g), .b_out(m_b)
    );

    // ---------------- tiny geometry, 3-bit colour ----------------
    logic        s_ce, s_hs, s_vs, s_hb, s_vb, s_ls;
    logic [8:0]  s_x, s_y;
    logic [2:0]  s_r, s_g, s_b;
    logic [8:0]  s_rgb;
    assign s_rgb = {s_y[2:0], s_x[2:0], 3'b101};

    video_timing_gen #(
        .CE_DIV(1), .H_TOTAL(16), .H_ACTIVE(8), .H_SS(10), .H_SW(2),
        .V_TOTAL(4), .V_ACTIVE(2), .V_SS(3), .V_SW(1), .HALF_DEPTH(1)
    ) u_small (
        .clk_sys(clk), .reset(reset), .rgb_in(s_rgb), .ce_pix(s_ce),
        .pix_x(s_x), .pix_y(s_y), .hs_out(s_hs), .vs_out(s_vs),
        .hblank(s_hb), .vblank(s_vb), .line_start(s_ls),
        .r_out(s_r), .g_out(s_g), .b_out(s_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Per-clock expectations for the first 20 clocks after reset release.
    typedef struct packed {
        logic       s_ce;
        logic [8:0] s_x;
        logic       s_hs;
        logic       s_hb;
        logic       s_ls;
        logic [8:0] s_rgb;
        logic       d_ce;
        logic [8:0] d_x;
        logic       d_hb;
        logic       d_ls;
    } cyc_vec_t;

    // Output expected one pixel enable after u_def presented (x, y).
    typedef struct packed {
        logic [8:0] x;
        logic [8:0] y;
        logic [5:0] r;
        logic [5:0] g;
        logic [5:0] b;
        logic       hb;
        logic       vb;
        logic       hs;
        logic       ls;
    } pix_vec_t;

    cyc_vec_t cyc_vec [20];
    pix_vec_t pix_vec [9];

    // ---------------- whole-frame monitor on u_mid ----------------
    int m_frame_cnt, m_hs_cnt, m_vs_cnt, m_outx, m_outy, m_vs_rises;
    bit m_active, m_seen_ls, m_seen_vs, m_prev_hs, m_prev_vs;

    initial begin
        m_vs_rises = 0;
        forever begin
            @(negedge clk);
            if (rst_seen || !mon_en) begin
                m_active = 0; m_seen_ls = 0; m_seen_vs = 0;
                m_prev_hs = 0; m_prev_vs = 0;
                m_frame_cnt = 0; m_hs_cnt = 0; m_vs_cnt = 0;
                m_outx = 0; m_outy = 39;
            end else if (!m_active) begin
                m_active = 1;   // first clock after release still shows reset outputs
            end else begin
                m_frame_cnt++;
                if (m_ls) begin
                    if (m_seen_ls) check("mid_hs_per_line", m_hs_cnt, 8);
                    m_seen_ls = 1;
                    m_hs_cnt = 0;
                    m_outx = 0;
                    m_outy = (m_outy + 1) % 40;
                    check("mid_vblank", int'(m_vb), int'(m_outy >= 24));
                    check("mid_vs_line", int'(m_vs), int'(m_outy >= 30 && m_outy < 33));
                end else begin
                    m_outx++;
                end
                if (m_hs) m_hs_cnt++;
                if (m_prev_hs && !m_hs) check("mid_hs_fall_x", m_outx, 48);
                if (m_vs && !m_prev_vs) begin
                    check("mid_vs_at_line0", int'(m_ls), 1);
                    if (m_seen_vs) check("mid_pix_per_frame", m_frame_cnt, 2560);
                    m_seen_vs = 1;
                    m_vs_rises++;
                    m_frame_cnt = 0;
                    m_vs_cnt = 0;
                end
                if (m_vs) m_vs_cnt++;
                if (m_prev_vs && !m_vs) check("mid_vs_width", m_vs_cnt, 192);
                check("mid_hblank", int'(m_hb), int'(m_outx >= 32));
                if (m_hb || m_vb)
                    check("mid_rgb_blank", int'({m_b, m_g, m_r}), 0);
                else
                    check("mid_rgb_active", int'({m_g, m_r}), int'({m_outx[5:0], 6'h2A}));
                m_prev_hs = m_hs;
                m_prev_vs = m_vs;
            end
        end
    end

    task automatic wait_def(input int x, input int y, output bit ok);
        int n;
        ok = 0;
        n = 0;
        while (!ok && n < 60000) begin
            @(negedge clk);
            if (d_ce && d_x == 9'(x) && d_y == 9'(y)) ok = 1;
            n++;
        end
        if (!ok) check("def_wait_timeout", 0, 1);
    endtask

    initial begin
        bit ok;
        int n;

        cyc_vec[0]  = '{1'b1, 9'd0,  1'b0, 1'b1, 1'b0, 9'o000, 1'b0, 9'd0, 1'b1, 1'b0};
        cyc_vec[1]  = '{1'b1, 9'd1,  1'b0, 1'b0, 1'b1, 9'o005, 1'b0, 9'd0, 1'b1, 1'b0};
        cyc_vec[2]  = '{1'b1, 9'd2,  1'b0, 1'b0, 1'b0, 9'o015, 1'b0, 9'd0, 1'b1, 1'b0};
        cyc_vec[3]  = '{1'b1, 9'd3,  1'b0, 1'b0, 1'b0, 9'o025, 1'b1, 9'd0, 1'b1, 1'b0};
        cyc_vec[4]  = '{1'b1, 9'd4,  1'b0, 1'b0, 1'b0, 9'o035, 1'b0, 9'd1, 1'b0, 1'b1};
        cyc_vec[5]  = '{1'b1, 9'd5,  1'b0, 1'b0, 1'b0, 9'o045, 1'b0, 9'd1, 1'b0, 1'b1};
        cyc_vec[6]  = '{1'b1, 9'd6,  1'b0, 1'b0, 1'b0, 9'o055, 1'b0, 9'd1, 1'b0, 1'b1};
        cyc_vec[7]  = '{1'b1, 9'd7,  1'b0, 1'b0, 1'b0, 9'o065, 1'b1, 9'd1, 1'b0, 1'b1};
        cyc_vec[8]  = '{1'b1, 9'd8,  1'b0, 1'b0, 1'b0, 9'o075, 1'b0, 9'd2, 1'b0, 1'b0};
        cyc_vec[9]  = '{1'b1, 9'd9,  1'b0, 1'b1, 1'b0, 9'o000, 1'b0, 9'd2, 1'b0, 1'b0};
        cyc_vec[10] = '{1'b1, 9'd10, 1'b0, 1'b1, 1'b0, 9'o000, 1'b0, 9'd2, 1'b0, 1'b0};
        cyc_vec[11] = '{1'b1, 9'd11, 1'b1, 1'b1, 1'b0, 9'o000, 1'b1, 9'd2, 1'b0, 1'b0};
        cyc_vec[12] = '{1'b1, 9'd12, 1'b1, 1'b1, 1'b0, 9'o000, 1'b0, 9'd3, 1'b0, 1'b0};
        cyc_vec[13] = '{1'b1, 9'd13, 1'b0, 1'b1, 1'b0, 9'o000, 1'b0, 9'd3, 1'b0, 1'b0};
        cyc_vec[14] = '{1'b1, 9'd14, 1'b0, 1'b1, 1'b0, 9'o000, 1'b0, 9'd3, 1'b0, 1'b0};
        cyc_vec[15] = '{1'b1, 9'd15, 1'b0, 1'b1, 1'b0, 9'o000, 1'b1, 9'd3, 1'b0, 1'b0};
        cyc_vec[16] = '{1'b1, 9'd0,  1'b0, 1'b1, 1'b0, 9'o000, 1'b0, 9'd4, 1'b0, 1'b0};
        cyc_vec[17] = '{1'b1, 9'd1,  1'b0, 1'b0, 1'b1, 9'o105, 1'b0, 9'd4, 1'b0, 1'b0};
        cyc_vec[18] = '{1'b1, 9'd2,  1'b0, 1'b0, 1'b0, 9'o115, 1'b0, 9'd4, 1'b0, 1'b0};
        cyc_vec[19] = '{1'b1, 9'd3,  1'b0, 1'b0, 1'b0, 9'o125, 1'b1, 9'd4, 1'b0, 1'b0};

        pix_vec[0] = '{9'd10,  9'd20, 6'h2A, 6'h0A, 6'h14, 1'b0, 1'b0, 1'b0, 1'b0};
        pix_vec[1] = '{9'd255, 9'd20, 6'h2A, 6'h3F, 6'h14, 1'b0, 1'b0, 1'b0, 1'b0};
        pix_vec[2] = '{9'd256, 9'd20, 6'h00, 6'h00, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        pix_vec[3] = '{9'd300, 9'd20, 6'h00, 6'h00, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        pix_vec[4] = '{9'd319, 9'd20, 6'h00, 6'h00, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        pix_vec[5] = '{9'd320, 9'd20, 6'h00, 6'h00, 6'h00, 1'b1, 1'b0, 1'b1, 1'b0};
        pix_vec[6] = '{9'd351, 9'd20, 6'h00, 6'h00, 6'h00, 1'b1, 1'b0, 1'b1, 1'b0};
        pix_vec[7] = '{9'd352, 9'd20, 6'h00, 6'h00, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        pix_vec[8] = '{9'd0,   9'd21, 6'h2A, 6'h00, 6'h15, 1'b0, 1'b0, 1'b0, 1'b1};

        reset  = 1'b1;
        mon_en = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_ce", int'(d_ce), 0);
        check("rst_xy", int'({d_x, d_y}), 0);
        check("rst_sync", int'({d_hs, d_vs}), 0);
        check("rst_blank", int'({d_hb, d_vb}), 3);
        check("rst_ls", int'(d_ls), 0);
        check("rst_rgb", int'({d_b, d_g, d_r}), 0);
        $display("reset: ce=%0b x=%0d y=%0d hs=%0b vs=%0b hb=%0b vb=%0b", d_ce, d_x, d_y, d_hs, d_vs, d_hb, d_vb);
        reset = 1'b0;

        // Clock-by-clock after release: u_small (CE_DIV=1) and u_def (CE_DIV=4).
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("small_ce", int'(s_ce), int'(cyc_vec[i].s_ce));
            check("small_x", int'(s_x), int'(cyc_vec[i].s_x));
            check("small_hs", int'(s_hs), int'(cyc_vec[i].s_hs));
            check("small_hblank", int'(s_hb), int'(cyc_vec[i].s_hb));
            check("small_line_start", int'(s_ls), int'(cyc_vec[i].s_ls));
            check("small_rgb", int'({s_b, s_g, s_r}), int'(cyc_vec[i].s_rgb));
            check("def_ce", int'(d_ce), int'(cyc_vec[i].d_ce));
            check("def_x", int'(d_x), int'(cyc_vec[i].d_x));
            check("def_hblank", int'(d_hb), int'(cyc_vec[i].d_hb));
            check("def_line_start", int'(d_ls), int'(cyc_vec[i].d_ls));
            $display("clk %0d: small x=%0d hs=%0b rgb=%o | def ce=%0b x=%0d ls=%0b",
                     i + 1, s_x, s_hs, {s_b, s_g, s_r}, d_ce, d_x, d_ls);
        end

        // u_small hsync over one whole line of output pixels 0..15.
        begin
            logic [15:0] hs_pat;
            hs_pat = '0;
            n = 0;
            while (!s_ls && n < 32) begin
                @(negedge clk);
                n++;
            end
            for (int i = 0; i < 16; i++) begin
                hs_pat[i] = s_hs;
                @(negedge clk);
            end
            check("small_hs_pattern", int'(hs_pat), int'(16'h0C00));
            $display("small hs pattern (bit=pixel): %b", hs_pat);
        end

        // u_mid frame wrap at (63, 39).
        ok = 0;
        n = 0;
        while (!ok && n < 5000) begin
            @(negedge clk);
            if (m_x == 9'd63 && m_y == 9'd39) ok = 1;
            n++;
        end
        check("mid_wrap_reached", int'(ok), 1);
        @(negedge clk);
        check("mid_wrap_xy", int'({m_x, m_y}), 0);
        @(negedge clk);
        check("mid_wrap_ls", int'(m_ls), 1);
        check("mid_wrap_vs", int'(m_vs), 0);
        check("mid_wrap_blank", int'({m_hb, m_vb}), 0);
        @(negedge clk);
        check("mid_ls_pixel1", int'(m_ls), 0);
        $display("mid wrap: x=%0d y=%0d vs=%0b", m_x, m_y, m_vs);

        // Selected default-geometry pixels, one pixel enable after presentation.
        for (int i = 0; i < 9; i++) begin
            wait_def(int'(pix_vec[i].x), int'(pix_vec[i].y), ok);
            @(negedge clk);
            check("def_r", int'(d_r), int'(pix_vec[i].r));
            check("def_g", int'(d_g), int'(pix_vec[i].g));
            check("def_b", int'(d_b), int'(pix_vec[i].b));
            check("def_hb", int'(d_hb), int'(pix_vec[i].hb));
            check("def_vb", int'(d_vb), int'(pix_vec[i].vb));
            check("def_hs", int'(d_hs), int'(pix_vec[i].hs));
            check("def_ls", int'(d_ls), int'(pix_vec[i].ls));
            @(negedge clk);
            check("def_hold_r", int'(d_r), int'(pix_vec[i].r));
            check("def_hold_hs", int'(d_hs), int'(pix_vec[i].hs));
            $display("pixel (%0d,%0d): r=%h g=%h b=%h hb=%0b vb=%0b hs=%0b ls=%0b",
                     pix_vec[i].x, pix_vec[i].y, d_r, d_g, d_b, d_hb, d_vb, d_hs, d_ls);
        end

        check("mid_frames_seen", int'(m_vs_rises >= 2), 1);

        // Mid-frame reset while hsync is active.
        wait_def(330, 21, ok);
        @(negedge clk);
        check("pre_rst_hs", int'(d_hs), 1);
        mon_en = 1'b0;
        reset  = 1'b1;
        @(negedge clk);
        check("mid_rst_ce", int'(d_ce), 0);
        check("mid_rst_xy", int'({d_x, d_y}), 0);
        check("mid_rst_sync", int'({d_hs, d_vs}), 0);
        check("mid_rst_blank", int'({d_hb, d_vb}), 3);
        check("mid_rst_ls", int'(d_ls), 0);
        check("mid_rst_rgb", int'({d_b, d_g, d_r}), 0);
        $display("mid-frame reset: x=%0d y=%0d hs=%0b hb=%0b", d_x, d_y, d_hs, d_hb);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("restart_ce", int'(d_ce), int'(k == 4 || k == 8));
            check("restart_x", int'(d_x), (k >= 5) ? 1 : 0);
            check("restart_y", int'(d_y), 0);
            check("restart_hs", int'(d_hs), 0);
            check("restart_ls", int'(d_ls), int'(k >= 5));
            $display("restart clk %0d: ce=%0b x=%0d y=%0d hs=%0b ls=%0b", k, d_ce, d_x, d_y, d_hs, d_ls);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
